bram_pattern_tester: RTL and testbench
======================================

Name: bram_pattern_tester

Overview:
Self-checking block RAM exerciser. It fills an inferred single-port BRAM with a selectable data pattern, reads every word back, compares each word against the regenerated expected value, and reports a pass/fail summary. It supersedes the fixed-width, fixed-pattern write/read loop. The whole block runs in one clock domain, downstream of the clock wizard's locked output. Width, depth, read latency, pattern and fault injection are all parametrised or run-time selectable.

Parameters:
DATA_WIDTH, 32, BRAM word width in bits (8..64).
ADDR_WIDTH, 10, address width; DEPTH = 2**ADDR_WIDTH words.
RD_LATENCY, 1, BRAM read latency in clocks (1 or 2; 2 adds an output register).
FAULT_ADDR, 3, address whose written word gets bit 0 inverted when fault injection is armed.
ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clk  in  1  single system clock.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  level; sampled only in IDLE; starts one test run.
mode  in  2  pattern select; latched at start.
fault_inj  in  1  arms single-bit fault at FAULT_ADDR; latched at start.
busy  out  1  high from the cycle after start is accepted until DONE.
done  out  1  one-cycle pulse at end of run.
pass  out  1  1 iff err_count == 0; updated with done, held until next start.
err_count  out  ERR_CNT_WIDTH  mismatch count; saturates at all-ones.
first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
read_data_out  out  DATA_WIDTH  last word read from the BRAM (monitor).
rd_valid  out  1  high in the cycle read_data_out carries a new compared word.

Behaviour:
- Reset (reset_n low, async):
  - FSM goes to IDLE.
  - All outputs 0; write and read address counters 0.
  - Latched mode and fault_inj cleared.
  - BRAM contents are not cleared.
  - Reset mid-run aborts immediately; done is not pulsed.
- Pattern for address a, zero-extended/truncated to DATA_WIDTH:
  - mode 0: a
  - mode 1: ~a (full DATA_WIDTH inversion of zero-extended a)
  - mode 2: walking one, 1 << (a mod DATA_WIDTH)
  - mode 3: checkerboard; 0x55..55 for even a, 0xAA..AA for odd a.
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge k: latch mode and fault_inj, clear err_count, first_err_addr and pass.
  - Go to WRITE; busy=1 from k+1.
- WRITE: one write per cycle, addresses 0..DEPTH-1 in order (DEPTH cycles). If fault_inj is latched, the word at FAULT_ADDR is written with bit 0 inverted.
- READ: one read issued per cycle, addresses 0..DEPTH-1 (DEPTH cycles).
  - The expected value and address travel down a RD_LATENCY-deep pipeline alongside the read.
  - Compare happens when the data emerges; rd_valid pulses that cycle.
- DRAIN: RD_LATENCY cycles to retire in-flight reads; comparisons continue.
- DONE: one cycle.
  - done=1, busy=0.
  - pass = (err_count == 0), including any mismatch compared in the final drain cycle.
  - Return to IDLE.
- Timing: done is high at cycle k+1+2*DEPTH+RD_LATENCY.
- Mismatch handling:
  - err_count increments by 1 per mismatching word, regardless of how many bits differ.
  - At all-ones it holds.
  - first_err_addr captured only on the first mismatch of the run.
- start is ignored outside IDLE.
- start held high through DONE launches a new run on the first IDLE cycle after DONE; the last run's results are cleared at that point.
- Address counters wrap from DEPTH-1 to 0 only at phase transitions; no read-before-write hazard exists because phases are strictly sequential.
- read_data_out and rd_valid behave the same for both RD_LATENCY values; only the timing shifts.

Test Plan:
1. DATA_WIDTH=32, ADDR_WIDTH=4, RD_LATENCY=1, mode 0, no fault, start pulse at cycle 10 -> busy cycles 11..43; done at cycle 44; pass=1; err_count=0; rd_valid pulses 16 times with read_data_out 0..15.
2. Same config, mode 2, fault_inj=1, FAULT_ADDR=3 -> read word at address 3 = 0x00000009; err_count=1; first_err_addr=3; pass=0.
3. RD_LATENCY=2, mode 3, ADDR_WIDTH=4 -> done at cycle k+35; read data alternates 0x55555555 / 0xAAAAAAAA; pass=1.
4. Drop reset_n low 5 cycles into READ -> all outputs 0 asynchronously, no done pulse; a new start then runs a full test with pass=1.
5. start held high continuously -> back-to-back runs with done pulses spaced 2*DEPTH+RD_LATENCY+2 cycles apart; second-run results are independent of the first.
6. DATA_WIDTH=8, ADDR_WIDTH=8, mode 1 -> word at address 0x05 reads 0xFA; pass=1; ERR_CNT_WIDTH=2 with fault forced on every word (bench forces the BRAM output) -> err_count saturates at 3.

Source files
------------

// File: rtl/bram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : bram_pattern_tester
// Purpose  : Fills an inferred BRAM with a selectable pattern, reads it back,
//            compares against the regenerated pattern and reports pass/fail.
// Revision : 1.0 - initial release
// ============================================================================
module bram_pattern_tester #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int RD_LATENCY    = 1,
    parameter int FAULT_ADDR    = 3,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic                     fault_inj,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic [DATA_WIDTH-1:0]    read_data_out,
    output logic                     rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [1:0]              r_mode;
    logic                    r_fault;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic [ADDR_WIDTH-1:0]   r_raddr;
    logic [1:0]              r_drain_cnt;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_bram_q;
    logic [DATA_WIDTH-1:0]   w_cmp_data;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_we;
    logic                    w_re;

    // Expected word and its address ride alongside each in-flight read.
    logic                    r_pv   [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   r_pexp [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   r_paddr[RD_LATENCY];

    logic                    w_cmp_valid;
    logic                    w_mismatch;
    logic [ERR_CNT_WIDTH-1:0] w_err_next;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m,
                                                       input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] p;
        logic [DATA_WIDTH-1:0] za;
        logic [31:0]           sh;
        p  = '0;
        za = DATA_WIDTH'(a);
        sh = 32'(a) % DATA_WIDTH;
        case (m)
            2'd0: p = za;
            2'd1: p = ~za;
            2'd2: p = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << sh;
            default: begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    p[i] = (i[0] == a[0]);
                end
            end
        endcase
        return p;
    endfunction

    assign w_we    = (r_state == S_WRITE);
    assign w_re    = (r_state == S_READ);
    assign w_wdata = pattern(r_mode, r_waddr) ^
                     DATA_WIDTH'(r_fault && (r_waddr == ADDR_WIDTH'(FAULT_ADDR)));

    // Memory array and its read register carry no reset so they map onto BRAM.
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[r_waddr] <= w_wdata;
        end
        if (w_re) begin
            r_bram_q <= mem[r_raddr];
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_outreg
            logic [DATA_WIDTH-1:0] r_bram_q2;
            always_ff @(posedge clk) begin
                r_bram_q2 <= r_bram_q;
            end
            assign w_cmp_data = r_bram_q2;
        end else begin : g_no_outreg
            assign w_cmp_data = r_bram_q;
        end
    endgenerate

    assign w_cmp_valid = r_pv[RD_LATENCY-1];
    assign w_mismatch  = w_cmp_valid && (w_cmp_data != r_pexp[RD_LATENCY-1]);
    assign w_err_next  = (w_mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

    assign busy = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_WRITE;
            S_WRITE: if (r_waddr == '1) w_state_next = S_READ;
            S_READ:  if (r_raddr == '1) w_state_next = S_DRAIN;
            S_DRAIN: if (r_drain_cnt == 2'(RD_LATENCY - 1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode         <= '0;
            r_fault        <= 1'b0;
            r_waddr        <= '0;
            r_raddr        <= '0;
            r_drain_cnt    <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            read_data_out  <= '0;
            rd_valid       <= 1'b0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pv[i]    <= 1'b0;
                r_pexp[i]  <= '0;
                r_paddr[i] <= '0;
            end
        end else begin
            r_pv[0]    <= w_re;
            r_pexp[0]  <= pattern(r_mode, r_raddr);
            r_paddr[0] <= r_raddr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pexp[i]  <= r_pexp[i-1];
                r_paddr[i] <= r_paddr[i-1];
            end

            rd_valid <= w_cmp_valid;
            if (w_cmp_valid) begin
                read_data_out <= w_cmp_data;
            end
            err_count <= w_err_next;
            // A saturating counter never returns to zero, so zero means no earlier miss.
            if (w_mismatch && (err_count == '0)) begin
                first_err_addr <= r_paddr[RD_LATENCY-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode         <= mode;
                        r_fault        <= fault_inj;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        r_waddr        <= '0;
                        r_raddr        <= '0;
                    end
                end
                S_WRITE: r_waddr <= r_waddr + 1'b1;
                S_READ: begin
                    r_raddr     <= r_raddr + 1'b1;
                    r_drain_cnt <= '0;
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (w_state_next == S_DONE) begin
                        pass <= (w_err_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_pattern_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_pattern_tester
// Purpose  : Directed self-checking bench for bram_pattern_tester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_pattern_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] mode;
    logic       fault_inj;
    logic       start_a, start_b, start_c;

    logic        busy_a, done_a, pass_a, rdv_a;
    logic [15:0] err_a;
    logic [3:0]  fea_a;
    logic [31:0] rdo_a;
    logic        busy_b, done_b, pass_b, rdv_b;
    logic [15:0] err_b;
    logic [3:0]  fea_b;
    logic [31:0] rdo_b;
    logic        busy_c, done_c, pass_c, rdv_c;
    logic [1:0]  err_c;
    logic [7:0]  fea_c;
    logic [7:0]  rdo_c;

    bram_pattern_tester #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1),
                          .FAULT_ADDR(3), .ERR_CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .mode(mode), .fault_inj(fault_inj),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_err_addr(fea_a), .read_data_out(rdo_a), .rd_valid(rdv_a));

    bram_pattern_tester #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2),
                          .FAULT_ADDR(3), .ERR_CNT_WIDTH(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode), .fault_inj(fault_inj),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_err_addr(fea_b), .read_data_out(rdo_b), .rd_valid(rdv_b));

    bram_pattern_tester #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RD_LATENCY(1),
                          .FAULT_ADDR(3), .ERR_CNT_WIDTH(2)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .mode(mode), .fault_inj(fault_inj),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .first_err_addr(fea_c), .read_data_out(rdo_c), .rd_valid(rdv_c));

    // Common view of whichever instance is under test.
    int          sel;
    logic        obs_busy, obs_done, obs_pass, obs_rdv;
    logic [15:0] obs_err;
    logic [7:0]  obs_fea;
    logic [31:0] obs_rdata;

    always_comb begin
        obs_busy = busy_a; obs_done = done_a; obs_pass = pass_a; obs_rdv = rdv_a;
        obs_err = err_a; obs_fea = {4'b0, fea_a}; obs_rdata = rdo_a;
        case (sel)
            1: begin
                obs_busy = busy_b; obs_done = done_b; obs_pass = pass_b; obs_rdv = rdv_b;
                obs_err = err_b; obs_fea = {4'b0, fea_b}; obs_rdata = rdo_b;
            end
            2: begin
                obs_busy = busy_c; obs_done = done_c; obs_pass = pass_c; obs_rdv = rdv_c;
                obs_err = {14'b0, err_c}; obs_fea = fea_c; obs_rdata = {24'b0, rdo_c};
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] rd_log [256];
    int log_idx;
    int lat, nbusy, gap, bad, ndone;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       start_b = v;
            2:       start_c = v;
            default: start_a = v;
        endcase
    endtask

    // Pulses start for one cycle (sampled at edge K); lat counts sample
    // points after K until done is seen, so done is expected at lat = 2*DEPTH+RD_LATENCY.
    task automatic do_run(input int s, input logic [1:0] m, input logic f,
                          output int l, output int nb);
        @(negedge clk);
        sel = s; mode = m; fault_inj = f; set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
        l = 0; nb = 0; log_idx = 0;
        while (!obs_done && l < 2000) begin
            if (obs_busy) nb++;
            if (obs_rdv && log_idx < 256) begin rd_log[log_idx] = obs_rdata; log_idx++; end
            l++;
            @(negedge clk);
        end
        if (obs_rdv && log_idx < 256) begin rd_log[log_idx] = obs_rdata; log_idx++; end
        if (l >= 2000) check("done_timeout", 64'(l), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; mode = 2'd0; fault_inj = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_busy_done_pass", {busy_a, done_a, pass_a, rdv_a}, 4'b0000);
        check("rst_err", err_a, 0);
        check("rst_rdata_fea", {rdo_a, fea_a}, 0);
        reset_n = 1'b1;

        // Mode 0, no fault.
        do_run(0, 2'd0, 1'b0, lat, nbusy);
        check("t1_latency", lat, 33);
        check("t1_busy_cycles", nbusy, 33);
        check("t1_busy_in_done", obs_busy, 0);
        check("t1_pass", obs_pass, 1);
        check("t1_err", obs_err, 0);
        check("t1_nvalid", log_idx, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (rd_log[i] !== 32'(i)) bad++;
        check("t1_rd_seq_bad", bad, 0);
        @(negedge clk);
        check("t1_done_one_cycle", obs_done, 0);

        // Walking one with fault at address 3: 0x8 ^ 1.
        do_run(0, 2'd2, 1'b1, lat, nbusy);
        check("t2_word3", rd_log[3], 32'h0000_0009);
        check("t2_word5", rd_log[5], 32'h0000_0020);
        check("t2_err", obs_err, 1);
        check("t2_first_err", obs_fea, 3);
        check("t2_pass", obs_pass, 0);

        // Two-cycle read latency, checkerboard.
        do_run(1, 2'd3, 1'b0, lat, nbusy);
        check("t3_latency", lat, 34);
        check("t3_word0", rd_log[0], 32'h5555_5555);
        check("t3_word1", rd_log[1], 32'hAAAA_AAAA);
        check("t3_word14", rd_log[14], 32'h5555_5555);
        check("t3_nvalid", log_idx, 16);
        check("t3_pass", obs_pass, 1);

        // Reset five cycles into READ.
        @(negedge clk);
        sel = 0; mode = 2'd0; fault_inj = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (21) @(negedge clk);
        check("t4_busy_before", busy_a, 1);
        reset_n = 1'b0;
        #1;
        check("t4_async_ctl", {busy_a, done_a, pass_a, rdv_a}, 4'b0000);
        check("t4_async_data", {rdo_a, err_a, fea_a}, 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) reset_n = 1'b1;
            if (done_a) ndone++;
        end
        check("t4_no_done", ndone, 0);
        do_run(0, 2'd0, 1'b0, lat, nbusy);
        check("t4_rerun_pass", obs_pass, 1);
        check("t4_rerun_latency", lat, 33);

        // start held high: first run faulted, second run clean.
        @(negedge clk);
        sel = 0; mode = 2'd0; fault_inj = 1'b1; start_a = 1'b1;
        @(negedge clk);
        fault_inj = 1'b0;
        lat = 0;
        while (!done_a && lat < 2000) begin lat++; @(negedge clk); end
        check("t5_run1_err", err_a, 1);
        check("t5_run1_fea", fea_a, 3);
        gap = 0;
        @(negedge clk); gap++;
        while (!done_a && gap < 2000) begin gap++; @(negedge clk); end
        start_a = 1'b0;
        check("t5_gap", gap, 35);
        check("t5_run2_err", err_a, 0);
        check("t5_run2_pass", pass_a, 1);

        // Narrow wide-depth config, inverted pattern.
        do_run(2, 2'd1, 1'b0, lat, nbusy);
        check("t6_latency", lat, 513);
        check("t6_word5", rd_log[5], 32'h0000_00FA);
        check("t6_pass", obs_pass, 1);

        // Forced BRAM data: every word except address 0 (~0 = 0xFF) mismatches.
        force dut_c.w_cmp_data = 8'hFF;
        do_run(2, 2'd1, 1'b0, lat, nbusy);
        release dut_c.w_cmp_data;
        check("t6_err_saturated", obs_err, 3);
        check("t6_first_err", obs_fea, 1);
        check("t6_forced_pass", obs_pass, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
